mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN_64b, width encoding; W = 1<<(XLEN+4) data bits, B = log2(W/8) byte-offset bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for i_mem_ack.
REQ-003 SHALL use clock i_clk; reset i_rst, synchronous, active-high.
REQ-004 i_clk  in  1  clock.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_mem_write_m  in  1  MEM-stage store.
REQ-007 i_store_byte_m / i_store_half_m  in  1 each  sub-word store (byte/half).
REQ-008 i_result_src_m  in  2  2'b01 = MEM-stage load.
REQ-009 i_f3_m  in  3  load width/sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
REQ-010 i_alu_out_m  in  W  byte address.
REQ-011 i_haz_b_m  in  W  store data, low bits significant.
REQ-012 o_mem_req / o_mem_we  out  1 each  memory request / write.
REQ-013 o_mem_addr  out  W  word-aligned address (low B bits zero).
REQ-014 o_mem_wdata  out  W  full-word write data.
REQ-015 i_mem_ack  in  1  access complete; i_mem_rdata  in  W  valid when i_mem_ack on read.
REQ-016 o_stall  out  1  drives clk_en low on all pipeline registers through EX/MEM.
REQ-017 o_load_data  out  W  extended load result; o_load_valid  out  1  result-valid pulse.
REQ-018 o_access_fault  out  1  one-cycle fault pulse; o_busy  out  1  state != IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-020 Access request = load | i_mem_write_m; misaligned = half offset odd, word offset not multiple of 4, full-W access offset nonzero.
REQ-021 IDLE: request and aligned -> RD if load or sub-word store, WR if full-word store; o_stall=1 combinationally that cycle.
REQ-022 IDLE: request and misaligned -> o_access_fault=1 for that cycle, no memory access, o_stall=0, stay IDLE.
REQ-023 RD/WR: o_mem_req=1, o_mem_we=1 only in WR, o_stall=1; address and data registered on IDLE exit, stable until ack.
REQ-024 RD on i_mem_ack: capture i_mem_rdata; load -> DONE; sub-word store -> WR with wdata = captured word with byte/half at offset replaced by i_haz_b_m[7:0]/[15:0].
REQ-025 WR on i_mem_ack -> DONE; ack accepted in first cycle of RD/WR.
REQ-026 DONE: o_stall=0, o_mem_req=0, one cycle, then IDLE unconditionally (prevents re-trigger of same instruction).
REQ-027 DONE after load: o_load_valid=1; o_load_data = selected field sign- or zero-extended per i_f3_m; held until next load completes.
REQ-028 Latency: load/full store 2 stall cycles, sub-word store 3, plus wait cycles before each ack.
REQ-029 Counter cleared on entering RD/WR; reaching TIMEOUT without ack -> o_access_fault pulse, o_mem_req drops, -> DONE with o_load_valid=0.
REQ-030 i_mem_ack outside RD/WR SHALL be ignored.

Reset
REQ-031 i_rst SHALL force IDLE, clear counter, and all outputs (o_mem_req, o_mem_we, o_stall, o_load_valid, o_access_fault, o_busy, o_mem_addr, o_mem_wdata, o_load_data) to 0 next cycle.
REQ-032 i_rst mid-access (RD/WR) SHALL abandon it; o_mem_req=0 the following cycle, no write issued.

Verification
REQ-033 ld 0x100, ack first RD cycle, rdata 0x1122334455667788 -> o_stall 2 cycles, then o_load_valid, o_load_data 0x1122334455667788.
REQ-034 lb 0x107, rdata 0x80FF_FFFF_FFFF_FFFF -> 0xFFFFFFFFFFFFFF80; lbu same -> 0x0000000000000080.
REQ-035 sb 0x102 data 0xAB, old word 0 -> RD addr 0x100, then WR wdata 0x0000000000AB0000, 3 stall cycles.
REQ-036 lh 0x101 -> o_access_fault 1 cycle, o_mem_req never high, o_stall 0.
REQ-037 load, no ack for 255 cycles -> o_access_fault pulse, o_mem_req low, DONE with o_load_valid 0, then IDLE.
REQ-038 i_rst during WR -> next cycle o_mem_req 0, o_stall 0, o_busy 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads and stores onto a simple
// req/ack memory port. Sub-word stores are done as read-modify-write.
// Load results are extracted and sign/zero-extended here. The pipeline is
// stalled while the access is outstanding. A watchdog turns a missing ack
// into an access fault.

`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module mem_access_ctrl #(
   parameter  int XLEN    = `XLEN_64b,   // width code, XLEN >= 1 (W >= 32)
   parameter  int TIMEOUT = 255,         // cycles to wait for an ack, >= 1
   localparam int W       = 1 << (XLEN + 4),
   localparam int B       = XLEN + 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_mem_write_m,
   input  logic         i_store_byte_m,
   input  logic         i_store_half_m,
   input  logic [1:0]   i_result_src_m,
   input  logic [2:0]   i_f3_m,
   input  logic [W-1:0] i_alu_out_m,
   input  logic [W-1:0] i_haz_b_m,
   output logic         o_mem_req,
   output logic         o_mem_we,
   output logic [W-1:0] o_mem_addr,
   output logic [W-1:0] o_mem_wdata,
   input  logic         i_mem_ack,
   input  logic [W-1:0] i_mem_rdata,
   output logic         o_stall,
   output logic [W-1:0] o_load_data,
   output logic         o_load_valid,
   output logic         o_access_fault,
   output logic         o_busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   // attributes of the access latched when it leaves IDLE
   typedef struct packed {
      logic         is_load;
      logic         sub_byte;
      logic [2:0]   f3;
      logic [B-1:0] off;
   } acc_t;

   state_t        state_q, state_d;
   acc_t          acc_q;
   logic [CW-1:0] cnt_q;
   logic          ld_ok_q;

   logic          is_load, is_sub, req, misal, go;
   logic          in_acc, tmo, ack_ok;
   logic [W-1:0]  rd_ext, wd_merge;

   // decode the MEM-stage instruction: request, sub-word, alignment
   always_comb begin : decode
      int           sz;
      logic [B-1:0] amask;
      is_load = (i_result_src_m == 2'b01);
      is_sub  = i_mem_write_m && !is_load && (i_store_byte_m || i_store_half_m);
      req     = is_load || i_mem_write_m;
      sz      = B;
      if (is_load)
         sz = (int'(i_f3_m[1:0]) > B) ? B : int'(i_f3_m[1:0]);
      else if (i_store_byte_m)
         sz = 0;
      else if (i_store_half_m)
         sz = 1;
      amask = B'((1 << sz) - 1);
      misal = |(i_alu_out_m[B-1:0] & amask);
      go    = req && !misal;
   end

   assign in_acc = (state_q == RD) || (state_q == WR);
   // the timeout cycle itself no longer requests, so a late ack is dropped
   assign tmo    = in_acc && (cnt_q == CW'(TIMEOUT));
   assign ack_ok = in_acc && !tmo && i_mem_ack;

   // pick the addressed field from the read word and extend it
   always_comb begin : load_ext
      logic [W-1:0] sh;
      int           drop;
      sh   = i_mem_rdata >> {acc_q.off, 3'b000};
      drop = (int'(acc_q.f3[1:0]) >= B) ? 0 : W - (8 << acc_q.f3[1:0]);
      sh   = sh << drop;
      if (acc_q.f3[2])
         rd_ext = sh >> drop;
      else
         rd_ext = W'($signed(sh) >>> drop);
   end

   // read-modify-write: drop the store byte/half into the fetched word
   always_comb begin : store_merge
      logic [W-1:0] mask, ins;
      if (acc_q.sub_byte) begin
         mask = W'(8'hFF) << {acc_q.off, 3'b000};
         ins  = W'(i_haz_b_m[7:0]) << {acc_q.off, 3'b000};
      end else begin
         mask = W'(16'hFFFF) << {acc_q.off, 3'b000};
         ins  = W'(i_haz_b_m[15:0]) << {acc_q.off, 3'b000};
      end
      wd_merge = (i_mem_rdata & ~mask) | ins;
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic; DONE always returns to IDLE so the same
   // instruction cannot start a second access
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (go) state_d = (is_load || is_sub) ? RD : WR;
         RD: begin
            if (tmo)         state_d = DONE;
            else if (ack_ok) state_d = acc_q.is_load ? DONE : WR;
         end
         WR:   if (tmo || ack_ok) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs; everything is held low while reset is asserted
   always_comb begin
      o_mem_req      = 1'b0;
      o_mem_we       = 1'b0;
      o_stall        = 1'b0;
      o_access_fault = 1'b0;
      o_load_valid   = 1'b0;
      o_busy         = 1'b0;
      if (!i_rst) begin
         o_busy = (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (req && misal) o_access_fault = 1'b1;
               else if (req)     o_stall        = 1'b1;
            end
            RD, WR: begin
               o_stall = 1'b1;
               if (tmo) o_access_fault = 1'b1;
               else begin
                  o_mem_req = 1'b1;
                  o_mem_we  = (state_q == WR);
               end
            end
            DONE:    o_load_valid = ld_ok_q;
            default: ;
         endcase
      end
   end

   // wait-cycle counter, restarted on every state change
   always_ff @(posedge i_clk) begin
      if (i_rst || (state_d != state_q)) cnt_q <= '0;
      else if (in_acc)                   cnt_q <= cnt_q + 1'b1;
   end

   // address/data latch at IDLE exit, read capture on ack in RD
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q       <= '0;
         ld_ok_q     <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_load_data <= '0;
      end else begin
         if (state_q == IDLE && go) begin
            acc_q.is_load  <= is_load;
            acc_q.sub_byte <= is_sub && i_store_byte_m;
            acc_q.f3       <= i_f3_m;
            acc_q.off      <= i_alu_out_m[B-1:0];
            ld_ok_q        <= 1'b0;
            o_mem_addr     <= {i_alu_out_m[W-1:B], B'(0)};
            o_mem_wdata    <= i_haz_b_m;
         end
         if (state_q == RD && ack_ok) begin
            if (acc_q.is_load) begin
               o_load_data <= rd_ext;
               ld_ok_q     <= 1'b1;
            end else begin
               o_mem_wdata <= wd_merge;
            end
         end
      end
   end

endmodule
